// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    localparam int ERR_MISALIGN = 0;
    localparam int ERR_RANGE    = 1;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic [1:0]  err;
    } rsp_t;

endpackage

// File: rtl/imem_responder_if.sv
// Fetch-side bundle: program load, request handshake, flush and response queue head.
interface imem_responder_if;
    logic        i_load_en;
    logic [31:0] i_load_addr;
    logic [31:0] i_load_data;
    logic        i_load_done;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [31:0] i_req_addr;
    logic        i_flush;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_instr;
    logic [31:0] o_rsp_addr;
    logic [1:0]  o_rsp_err;
    logic        o_busy;

    modport master (
        output i_load_en, i_load_addr, i_load_data, i_load_done,
        output i_req_valid, i_req_addr, i_flush, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_instr, o_rsp_addr, o_rsp_err, o_busy
    );

    modport slave (
        input  i_load_en, i_load_addr, i_load_data, i_load_done,
        input  i_req_valid, i_req_addr, i_flush, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_instr, o_rsp_addr, o_rsp_err, o_busy
    );
endinterface

// File: rtl/imem_rsp_fifo.sv
// Two-entry response FIFO with flush; an entry pushed while empty is visible the same cycle.
module imem_rsp_fifo #(
    parameter int WIDTH = 66
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_rdy_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] dat_o,
    output logic [1:0]       count_o
);
    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             empty, pop, store, drop;

    assign empty   = (count_q == 2'd0);
    assign vld_o   = !flush_i && (!empty || push_i);
    assign dat_o   = empty ? push_dat_i : mem_q[rd_ptr_q];
    assign pop     = vld_o && pop_rdy_i;
    assign count_o = count_q;

    // A push into an empty queue that is popped on arrival never occupies a slot.
    always_comb begin
        store    = push_i && !flush_i && !(empty && pop);
        drop     = pop && !empty;
        wr_ptr_d = wr_ptr_q ^ store;
        rd_ptr_d = rd_ptr_q ^ drop;
        count_d  = count_q + {1'b0, store} - {1'b0, drop};
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction memory with program-load phase, one-cycle read latency and a 2-entry response queue.
module imem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input logic              clk,
    input logic              rst,
    imem_responder_if.slave  bus
);
    import imem_pkg::*;

    localparam int AW = $clog2(DEPTH_WORDS);

    state_e      state_q, state_d;
    logic        inflight_q, inflight_d;
    logic [31:0] infl_addr_q, infl_addr_d;
    logic [1:0]  infl_err_q, infl_err_d;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rd_data_q;

    logic [1:0]  req_err;
    logic [1:0]  count;
    logic [1:0]  occupancy;
    logic        accept;
    logic        rsp_vld;
    rsp_t        push_dat;
    rsp_t        head;

    assign req_err[ERR_MISALIGN] = (bus.i_req_addr[1:0] != 2'b00);
    assign req_err[ERR_RANGE]    = (bus.i_req_addr[31:AW+2] != '0);

    // Ready looks only at registered occupancy so every accepted read has a slot.
    assign occupancy       = count + {1'b0, inflight_q};
    assign bus.o_req_ready = (state_q == S_RUN) && !bus.i_flush && (occupancy < 2'd2);
    assign accept          = bus.i_req_valid && bus.o_req_ready;

    always_comb begin
        state_d     = state_q;
        inflight_d  = accept;
        infl_addr_d = infl_addr_q;
        infl_err_d  = infl_err_q;
        if (state_q == S_LOAD && bus.i_load_done) begin
            state_d = S_RUN;
        end
        if (accept) begin
            infl_addr_d = bus.i_req_addr;
            infl_err_d  = req_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_LOAD;
            inflight_q  <= 1'b0;
            infl_addr_q <= '0;
            infl_err_q  <= '0;
        end else begin
            state_q     <= state_d;
            inflight_q  <= inflight_d;
            infl_addr_q <= infl_addr_d;
            infl_err_q  <= infl_err_d;
        end
    end

    // Array has no reset so a program survives rst.
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD && bus.i_load_en) begin
            mem[bus.i_load_addr[AW+1:2]] <= bus.i_load_data;
        end
        if (accept && req_err == 2'b00) begin
            rd_data_q <= mem[bus.i_req_addr[AW+1:2]];
        end
    end

    always_comb begin
        push_dat.instr = (infl_err_q != 2'b00) ? NOP_INSTR : rd_data_q;
        push_dat.addr  = infl_addr_q;
        push_dat.err   = infl_err_q;
    end

    imem_rsp_fifo #(
        .WIDTH($bits(rsp_t))
    ) u_rsp_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (bus.i_flush),
        .push_i     (inflight_q),
        .push_dat_i (push_dat),
        .pop_rdy_i  (bus.i_rsp_ready),
        .vld_o      (rsp_vld),
        .dat_o      (head),
        .count_o    (count)
    );

    assign bus.o_rsp_valid = rsp_vld;
    assign bus.o_rsp_instr = rsp_vld ? head.instr : 32'h0;
    assign bus.o_rsp_addr  = rsp_vld ? head.addr  : 32'h0;
    assign bus.o_rsp_err   = rsp_vld ? head.err   : 2'b00;
    assign bus.o_busy      = inflight_q || (count != 2'd0);

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed scenarios plus randomized traffic against a queue-based model.
module tb_imem_responder;
    localparam int DEPTH = 256;
    localparam logic [31:0] W0 = 32'h00A0_0093;
    localparam logic [31:0] W1 = 32'h00B0_0113;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic [1:0]  err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_responder_if bus();

    imem_responder #(.DEPTH_WORDS(DEPTH), .NOP_INSTR(32'h0000_0013)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mmem [DEPTH];
    bit          m_run;
    exp_t        m_q[$];
    bit          m_pend_v;
    exp_t        m_pend;
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic exp_t expect_rsp(input logic [31:0] a);
        exp_t e;
        e.addr   = a;
        e.err[0] = (a % 4) != 0;
        e.err[1] = (a / 4) >= DEPTH;
        if (e.err != 2'b00) e.instr = 32'h0000_0013;
        else                e.instr = mmem[a / 4];
        return e;
    endfunction

    function automatic bit m_valid();
        return !bus.i_flush && (m_q.size() != 0 || m_pend_v);
    endfunction

    function automatic bit m_ready();
        return m_run && !bus.i_flush && (m_q.size() + int'(m_pend_v)) < 2;
    endfunction

    function automatic exp_t m_head();
        exp_t z;
        z = '0;
        if (!m_valid()) return z;
        if (m_q.size() != 0) return m_q[0];
        return m_pend;
    endfunction

    function automatic bit m_busy();
        return m_pend_v || m_q.size() != 0;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pend_v = 0;
        m_run    = 0;
    endtask

    // Advance one clock: update the model from the current inputs, then move to the next negedge.
    task automatic tick();
        bit   v, r, pop, acc;
        exp_t nr;
        v   = m_valid();
        r   = m_ready();
        pop = v && bus.i_rsp_ready;
        acc = r && bus.i_req_valid;
        nr  = expect_rsp(bus.i_req_addr);
        if (!m_run && bus.i_load_en) mmem[(bus.i_load_addr >> 2) % DEPTH] = bus.i_load_data;
        if (bus.i_flush) begin
            m_q.delete();
            m_pend_v = 0;
        end else begin
            if (pop) begin
                if (m_q.size() != 0) void'(m_q.pop_front());
                else m_pend_v = 0;
            end
            if (m_pend_v) m_q.push_back(m_pend);
            m_pend_v = acc;
            m_pend   = nr;
        end
        if (!m_run && bus.i_load_done) m_run = 1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_idle();
        bus.i_load_en   = 0;
        bus.i_load_addr = '0;
        bus.i_load_data = '0;
        bus.i_load_done = 0;
        bus.i_req_valid = 0;
        bus.i_req_addr  = '0;
        bus.i_flush     = 0;
        bus.i_rsp_ready = 1;
    endtask

    task automatic drain();
        drive_idle();
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1;
        model_reset();
        @(negedge clk);
        #1;
        n_checks++; if (bus.o_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", bus.o_req_ready); end
        n_checks++; if (bus.o_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.o_rsp_valid); end
        n_checks++; if (bus.o_rsp_instr !== 32'h0 || bus.o_rsp_addr !== 32'h0 || bus.o_rsp_err !== 2'b00) begin
            n_fail++; $display("FAIL reset_data got %h/%h/%b want zeros", bus.o_rsp_instr, bus.o_rsp_addr, bus.o_rsp_err);
        end
        n_checks++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.o_busy); end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_load();
        for (int i = 0; i < DEPTH; i++) begin
            bus.i_load_en   = 1;
            bus.i_load_addr = (i * 4) | $urandom_range(0, 3);
            bus.i_load_data = (i == 0) ? W0 : (i == 1) ? W1 : $urandom;
            bus.i_load_done = (i == DEPTH - 1);
            bus.i_req_valid = 1;
            bus.i_req_addr  = 32'h0;
            #1;
            n_checks++; if (bus.o_req_ready !== 1'b0) begin n_fail++; $display("FAIL load_ready i=%0d got %b want 0", i, bus.o_req_ready); end
            tick();
        end
        drive_idle();
        #1;
        n_checks++; if (bus.o_req_ready !== 1'b1) begin n_fail++; $display("FAIL run_ready got %b want 1", bus.o_req_ready); end
        tick();
    endtask

    task automatic test_basic();
        drive_idle();
        bus.i_req_valid = 1;
        bus.i_req_addr  = 32'h0;
        tick();
        bus.i_req_addr  = 32'h4;
        #1;
        n_checks++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_instr !== W0 || bus.o_rsp_addr !== 32'h0 || bus.o_rsp_err !== 2'b00) begin
            n_fail++; $display("FAIL basic_rsp0 got v=%b %h @%h e=%b want 1 %h @0 e=00", bus.o_rsp_valid, bus.o_rsp_instr, bus.o_rsp_addr, bus.o_rsp_err, W0);
        end
        n_checks++; if (bus.o_req_ready !== 1'b1) begin n_fail++; $display("FAIL basic_b2b_ready got %b want 1", bus.o_req_ready); end
        tick();
        bus.i_req_valid = 0;
        #1;
        n_checks++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_instr !== W1 || bus.o_rsp_addr !== 32'h4 || bus.o_rsp_err !== 2'b00) begin
            n_fail++; $display("FAIL basic_rsp1 got v=%b %h @%h e=%b want 1 %h @4 e=00", bus.o_rsp_valid, bus.o_rsp_instr, bus.o_rsp_addr, bus.o_rsp_err, W1);
        end
        drain();
    endtask

    task automatic test_errors();
        logic [31:0] addrs [3];
        logic [1:0]  errs  [3];
        addrs[0] = 32'h6;   errs[0] = 2'b01;
        addrs[1] = 32'h400; errs[1] = 2'b10;
        addrs[2] = 32'h402; errs[2] = 2'b11;
        for (int k = 0; k < 3; k++) begin
            drive_idle();
            bus.i_req_valid = 1;
            bus.i_req_addr  = addrs[k];
            tick();
            bus.i_req_valid = 0;
            #1;
            n_checks++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_instr !== 32'h13 || bus.o_rsp_err !== errs[k] || bus.o_rsp_addr !== addrs[k]) begin
                n_fail++; $display("FAIL err_%0h got v=%b %h e=%b @%h want 1 00000013 e=%b", addrs[k], bus.o_rsp_valid, bus.o_rsp_instr, bus.o_rsp_err, bus.o_rsp_addr, errs[k]);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic exp_rdy [3];
        exp_rdy[0] = 1; exp_rdy[1] = 1; exp_rdy[2] = 0;
        drive_idle();
        bus.i_rsp_ready = 0;
        bus.i_req_valid = 1;
        for (int k = 0; k < 3; k++) begin
            bus.i_req_addr = 32'h8 + 32'(k * 4);
            #1;
            n_checks++; if (bus.o_req_ready !== exp_rdy[k]) begin n_fail++; $display("FAIL bp_ready k=%0d got %b want %b", k, bus.o_req_ready, exp_rdy[k]); end
            tick();
        end
        bus.i_req_valid = 0;
        #1;
        n_checks++; if (bus.o_req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got %b want 0", bus.o_req_ready); end
        bus.i_rsp_ready = 1;
        #1;
        n_checks++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_addr !== 32'h8 || bus.o_rsp_instr !== mmem[2]) begin
            n_fail++; $display("FAIL bp_head0 got v=%b %h @%h want 1 %h @8", bus.o_rsp_valid, bus.o_rsp_instr, bus.o_rsp_addr, mmem[2]);
        end
        tick();
        #1;
        n_checks++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_addr !== 32'hC || bus.o_rsp_instr !== mmem[3]) begin
            n_fail++; $display("FAIL bp_head1 got v=%b %h @%h want 1 %h @c", bus.o_rsp_valid, bus.o_rsp_instr, bus.o_rsp_addr, mmem[3]);
        end
        n_checks++; if (bus.o_req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_reopen got %b want 1", bus.o_req_ready); end
        tick();
        #1;
        n_checks++; if (bus.o_rsp_valid !== 1'b0 || bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL bp_drained got v=%b busy=%b want 0 0", bus.o_rsp_valid, bus.o_busy); end
        drain();
    endtask

    task automatic test_flush();
        drive_idle();
        bus.i_rsp_ready = 0;
        bus.i_req_valid = 1;
        bus.i_req_addr  = 32'h8;
        tick();
        bus.i_req_addr  = 32'hC;
        tick();
        bus.i_req_valid = 0;
        tick();
        #1;
        n_checks++; if (bus.o_rsp_valid !== 1'b1 || bus.o_busy !== 1'b1 || bus.o_req_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_pre got v=%b busy=%b rdy=%b want 1 1 0", bus.o_rsp_valid, bus.o_busy, bus.o_req_ready);
        end
        bus.i_flush     = 1;
        bus.i_req_valid = 1;
        #1;
        n_checks++; if (bus.o_req_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %b want 0", bus.o_req_ready); end
        tick();
        bus.i_flush     = 0;
        bus.i_req_valid = 0;
        #1;
        n_checks++; if (bus.o_rsp_valid !== 1'b0 || bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL flush_post got v=%b busy=%b want 0 0", bus.o_rsp_valid, bus.o_busy); end
        bus.i_rsp_ready = 1;
        bus.i_req_valid = 1;
        bus.i_req_addr  = 32'h4;
        tick();
        bus.i_req_valid = 0;
        #1;
        n_checks++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_instr !== W1 || bus.o_rsp_addr !== 32'h4) begin
            n_fail++; $display("FAIL flush_next got v=%b %h @%h want 1 %h @4", bus.o_rsp_valid, bus.o_rsp_instr, bus.o_rsp_addr, W1);
        end
        drain();
    endtask

    task automatic test_load_ignored();
        drive_idle();
        bus.i_load_en   = 1;
        bus.i_load_addr = 32'h0;
        bus.i_load_data = 32'hFFFF_FFFF;
        tick();
        bus.i_load_en   = 0;
        bus.i_req_valid = 1;
        bus.i_req_addr  = 32'h0;
        tick();
        bus.i_req_valid = 0;
        #1;
        n_checks++; if (bus.o_rsp_instr !== W0) begin n_fail++; $display("FAIL run_load_ignored got %h want %h", bus.o_rsp_instr, W0); end
        drain();
    endtask

    task automatic test_random();
        exp_t eh;
        bit   ev;
        for (int i = 0; i < 3000; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            bus.i_req_valid = ($urandom_range(0, 3) != 0);
            if (sel < 7)       bus.i_req_addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            else if (sel == 7) bus.i_req_addr = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
            else if (sel == 8) bus.i_req_addr = 32'($urandom_range(256, 4095)) << 2;
            else               bus.i_req_addr = $urandom;
            bus.i_rsp_ready = ($urandom_range(0, 9) < 7);
            bus.i_flush     = ($urandom_range(0, 15) == 0);
            bus.i_load_en   = ($urandom_range(0, 7) == 0);
            bus.i_load_addr = $urandom;
            bus.i_load_data = $urandom;
            #1;
            ev = m_valid();
            eh = m_head();
            n_checks++; if (bus.o_req_ready !== m_ready()) begin n_fail++; $display("FAIL rnd_ready cyc=%0d got %b want %b", i, bus.o_req_ready, m_ready()); end
            n_checks++; if (bus.o_rsp_valid !== ev) begin n_fail++; $display("FAIL rnd_valid cyc=%0d got %b want %b", i, bus.o_rsp_valid, ev); end
            n_checks++; if (bus.o_rsp_instr !== eh.instr) begin n_fail++; $display("FAIL rnd_instr cyc=%0d got %h want %h", i, bus.o_rsp_instr, eh.instr); end
            n_checks++; if (bus.o_rsp_addr !== eh.addr) begin n_fail++; $display("FAIL rnd_addr cyc=%0d got %h want %h", i, bus.o_rsp_addr, eh.addr); end
            n_checks++; if (bus.o_rsp_err !== eh.err) begin n_fail++; $display("FAIL rnd_err cyc=%0d got %b want %b", i, bus.o_rsp_err, eh.err); end
            n_checks++; if (bus.o_busy !== m_busy()) begin n_fail++; $display("FAIL rnd_busy cyc=%0d got %b want %b", i, bus.o_busy, m_busy()); end
            tick();
        end
        drain();
    endtask

    task automatic test_reset_midop();
        drive_idle();
        bus.i_rsp_ready = 0;
        bus.i_req_valid = 1;
        bus.i_req_addr  = 32'h10;
        tick();
        bus.i_req_addr  = 32'h14;
        tick();
        bus.i_req_valid = 0;
        #1;
        n_checks++; if (bus.o_busy !== 1'b1 || bus.o_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL midop_pre got busy=%b v=%b want 1 1", bus.o_busy, bus.o_rsp_valid); end
        rst = 1;
        model_reset();
        #1;
        n_checks++; if (bus.o_rsp_valid !== 1'b0 || bus.o_rsp_instr !== 32'h0 || bus.o_rsp_addr !== 32'h0 || bus.o_rsp_err !== 2'b00 || bus.o_busy !== 1'b0) begin
            n_fail++; $display("FAIL midop_rst got v=%b %h @%h e=%b busy=%b want all zero", bus.o_rsp_valid, bus.o_rsp_instr, bus.o_rsp_addr, bus.o_rsp_err, bus.o_busy);
        end
        n_checks++; if (bus.o_req_ready !== 1'b0) begin n_fail++; $display("FAIL midop_rst_ready got %b want 0", bus.o_req_ready); end
        @(negedge clk);
        rst = 0;
        bus.i_rsp_ready = 1;
        bus.i_load_done = 1;
        #1;
        n_checks++; if (bus.o_req_ready !== 1'b0) begin n_fail++; $display("FAIL midop_load_ready got %b want 0", bus.o_req_ready); end
        tick();
        bus.i_load_done = 0;
        bus.i_req_valid = 1;
        bus.i_req_addr  = 32'h0;
        #1;
        n_checks++; if (bus.o_req_ready !== 1'b1) begin n_fail++; $display("FAIL midop_run_ready got %b want 1", bus.o_req_ready); end
        tick();
        bus.i_req_valid = 0;
        #1;
        n_checks++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_instr !== W0) begin n_fail++; $display("FAIL midop_kept got v=%b %h want 1 %h", bus.o_rsp_valid, bus.o_rsp_instr, W0); end
        drain();
    endtask

    initial begin
        test_reset();
        test_load();
        test_basic();
        test_errors();
        test_backpressure();
        test_flush();
        test_load_ignored();
        test_random();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
